// File: rtl/mem_req_master_pkg.sv
// Shared constants, request payload and helpers for the data-memory request master.
package mem_req_master_pkg;

  localparam int unsigned XLEN = 32;

  // Access size encodings on io_req_typ; any other value behaves as MT_W
  localparam logic [2:0] MT_B  = 3'd1;
  localparam logic [2:0] MT_H  = 3'd2;
  localparam logic [2:0] MT_W  = 3'd3;
  localparam logic [2:0] MT_BU = 3'd5;
  localparam logic [2:0] MT_HU = 3'd6;

  localparam logic FCN_LD = 1'b0;
  localparam logic FCN_ST = 1'b1;

  // Must match the data memory's func decode
  localparam logic [1:0] MEM_FUNC_RD = 2'h0;
  localparam logic [1:0] MEM_FUNC_WR = 2'h1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_RMW_RD,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            fcn;
    logic [2:0]      typ;
  } mem_req_t;

  // Halfwords need an even address, words (and unknown sizes) a word-aligned one
  function automatic logic is_misaligned(input logic [2:0] typ, input logic [1:0] lane);
    case (typ)
      MT_B, MT_BU: return 1'b0;
      MT_H, MT_HU: return lane[0];
      default:     return |lane;
    endcase
  endfunction

  // Sub-word accesses; stores of these sizes need a read-modify-write
  function automatic logic is_sub_word(input logic [2:0] typ);
    case (typ)
      MT_B, MT_BU, MT_H, MT_HU: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane alignment for the request master (purely combinational).
//   word    : word read from memory
//   wdata   : right-aligned store data
//   lane    : byte address bits [1:0]
//   typ     : access size
//   ld_data : selected lane, sign/zero extended (load path)
//   st_data : word with the store lane merged in (store path)
module mem_lane_align
  import mem_req_master_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [XLEN-1:0] wdata,
  input  logic [1:0]      lane,
  input  logic [2:0]      typ,
  output logic [XLEN-1:0] ld_data,
  output logic [XLEN-1:0] st_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lane selection
  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  // Load extension
  always_comb begin
    ld_data = word;
    case (typ)
      MT_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
      MT_BU:   ld_data = {24'h0, byte_sel};
      MT_H:    ld_data = {{16{half_sel[15]}}, half_sel};
      MT_HU:   ld_data = {16'h0, half_sel};
      default: ld_data = word;
    endcase
  end

  // Store merge
  always_comb begin
    st_data = word;
    case (typ)
      MT_B, MT_BU: begin
        case (lane)
          2'd0: st_data[7:0]   = wdata[7:0];
          2'd1: st_data[15:8]  = wdata[7:0];
          2'd2: st_data[23:16] = wdata[7:0];
          2'd3: st_data[31:24] = wdata[7:0];
          default: st_data = word;
        endcase
      end
      MT_H, MT_HU: begin
        if (lane[1]) st_data[31:16] = wdata[15:0];
        else         st_data[15:0]  = wdata[15:0];
      end
      default: st_data = wdata;
    endcase
  end

endmodule

// File: rtl/mem_req_master.sv
// Load/store request master for the single-port word-wide data memory.
//   io_req_*   : valid/ready request from the memory stage (addr, wdata, fcn, typ)
//   io_resp_*  : one-cycle response pulse with extended load data / misalign error
//   io_mem_*   : memory side (en, func, word address, write data, comb read data)
module mem_req_master
  import mem_req_master_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            io_req_valid,
  output logic            io_req_ready,
  input  logic [XLEN-1:0] io_req_addr,
  input  logic [XLEN-1:0] io_req_wdata,
  input  logic            io_req_fcn,
  input  logic [2:0]      io_req_typ,
  output logic            io_resp_valid,
  output logic [XLEN-1:0] io_resp_data,
  output logic            io_resp_err,
  output logic [XLEN-1:0] io_mem_addr,
  output logic [XLEN-1:0] io_mem_wr_data,
  output logic [1:0]      io_mem_func,
  output logic            io_mem_en,
  input  logic [XLEN-1:0] io_mem_rd_data
);

  state_e          state_q, state_d;
  mem_req_t        req_c;
  logic            accept_c;
  logic            misaligned_c;
  logic [1:0]      lane_q;
  logic [2:0]      typ_q;
  logic [XLEN-1:0] wdata_q;
  logic [XLEN-1:0] resp_data_q;
  logic            resp_err_q;
  logic [XLEN-1:0] mem_addr_q;
  logic [XLEN-1:0] mem_wr_data_q;
  logic [XLEN-1:0] ld_data_c;
  logic [XLEN-1:0] st_data_c;

  assign req_c = '{addr: io_req_addr, wdata: io_req_wdata, fcn: io_req_fcn, typ: io_req_typ};

  assign io_req_ready = (state_q == ST_IDLE) & reset_n;
  assign accept_c     = io_req_valid & io_req_ready;
  assign misaligned_c = is_misaligned(req_c.typ, req_c.addr[1:0]);

  mem_lane_align u_align (
    .word    (io_mem_rd_data),
    .wdata   (wdata_q),
    .lane    (lane_q),
    .typ     (typ_q),
    .ld_data (ld_data_c),
    .st_data (st_data_c)
  );

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next state and state-decoded memory/response strobes
  always_comb begin
    state_d       = state_q;
    io_mem_en     = 1'b0;
    io_mem_func   = MEM_FUNC_RD;
    io_resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (misaligned_c)                state_d = ST_RESP;
          else if (req_c.fcn == FCN_LD)    state_d = ST_READ;
          else if (is_sub_word(req_c.typ)) state_d = ST_RMW_RD;
          else                             state_d = ST_WRITE;
        end
      end
      ST_READ: begin
        io_mem_en = 1'b1;
        state_d   = ST_RESP;
      end
      ST_RMW_RD: begin
        io_mem_en = 1'b1;
        state_d   = ST_WRITE;
      end
      ST_WRITE: begin
        io_mem_en   = 1'b1;
        io_mem_func = MEM_FUNC_WR;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        io_resp_valid = 1'b1;
        state_d       = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Latched request fields and datapath registers; memory address/data only
  // move for aligned requests so they hold while the memory is idle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lane_q        <= 2'd0;
      typ_q         <= MT_W;
      wdata_q       <= '0;
      resp_data_q   <= '0;
      resp_err_q    <= 1'b0;
      mem_addr_q    <= '0;
      mem_wr_data_q <= '0;
    end else begin
      if (accept_c) begin
        lane_q      <= req_c.addr[1:0];
        typ_q       <= req_c.typ;
        wdata_q     <= req_c.wdata;
        resp_data_q <= '0;
        resp_err_q  <= misaligned_c;
        if (!misaligned_c) begin
          mem_addr_q <= {2'b00, req_c.addr[XLEN-1:2]};
          if (req_c.fcn == FCN_ST && !is_sub_word(req_c.typ))
            mem_wr_data_q <= req_c.wdata;
        end
      end
      if (state_q == ST_READ)   resp_data_q   <= ld_data_c;
      if (state_q == ST_RMW_RD) mem_wr_data_q <= st_data_c;
    end
  end

  assign io_resp_data   = resp_data_q;
  assign io_resp_err    = resp_err_q;
  assign io_mem_addr    = mem_addr_q;
  assign io_mem_wr_data = mem_wr_data_q;

endmodule

// File: tb/tb_mem_req_master.sv
// Directed bench for mem_req_master with a small word memory model.
module tb_mem_req_master;
  import mem_req_master_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_fcn;
  logic [2:0]  req_typ;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [1:0]  mem_func;
  logic        mem_en;
  logic [31:0] mem_rd_data;

  logic [31:0] mem [16];
  logic        bd_we;
  logic [3:0]  bd_idx;
  logic [31:0] bd_val;

  int checks = 0;
  int errors = 0;

  mem_req_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .io_req_valid   (req_valid),
    .io_req_ready   (req_ready),
    .io_req_addr    (req_addr),
    .io_req_wdata   (req_wdata),
    .io_req_fcn     (req_fcn),
    .io_req_typ     (req_typ),
    .io_resp_valid  (resp_valid),
    .io_resp_data   (resp_data),
    .io_resp_err    (resp_err),
    .io_mem_addr    (mem_addr),
    .io_mem_wr_data (mem_wr_data),
    .io_mem_func    (mem_func),
    .io_mem_en      (mem_en),
    .io_mem_rd_data (mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, write on the rising edge
  assign mem_rd_data = mem[mem_addr[3:0]];
  always @(posedge clk) begin
    if (mem_en && mem_func == MEM_FUNC_WR) mem[mem_addr[3:0]] <= mem_wr_data;
    else if (bd_we)                        mem[bd_idx]        <= bd_val;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [3:0] idx, input logic [31:0] val);
    bd_idx = idx;
    bd_val = val;
    bd_we  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bd_we  = 1'b0;
  endtask

  // Issue one request from IDLE and watch up to 6 cycles; called and returns at a negedge
  task automatic run_req(input string tag, input logic fcn, input logic [2:0] typ,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input int exp_lat, input logic [31:0] exp_data, input logic exp_err,
                         output logic en_seen, output logic [31:0] addr_seen,
                         output logic [31:0] wr_seen);
    int          lat;
    int          pulses;
    logic        rdy_after;
    logic [31:0] data_seen;
    logic        err_seen;
    lat = 0; pulses = 0; rdy_after = 1'b0; data_seen = '0; err_seen = 1'b0;
    en_seen = 1'b0; addr_seen = '0; wr_seen = '0;
    check({tag, " ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_fcn = fcn; req_typ = typ; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) @(negedge clk);
      if (mem_en) begin
        if (!en_seen) addr_seen = mem_addr;
        en_seen = 1'b1;
        if (mem_func == MEM_FUNC_WR) wr_seen = mem_wr_data;
      end
      if (lat != 0 && i == lat + 1) rdy_after = req_ready;
      if (resp_valid) begin
        pulses++;
        lat       = i;
        data_seen = resp_data;
        err_seen  = resp_err;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " pulses"}, 32'(pulses), 32'd1);
    check({tag, " data"}, data_seen, exp_data);
    check({tag, " err"}, 32'(err_seen), 32'(exp_err));
    check({tag, " ready after"}, 32'(rdy_after), 32'd1);
  endtask

  logic        en_s;
  logic [31:0] addr_s;
  logic [31:0] wr_s;
  logic [31:0] rd_a, rd_b;
  int          pa, pb;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_wdata = '0;
    req_fcn = FCN_LD; req_typ = MT_W; bd_we = 1'b0; bd_idx = '0; bd_val = '0;
    @(negedge clk);
    poke(4'd0, 32'h0000_0000);
    poke(4'd1, 32'h80FF_0000);
    poke(4'd2, 32'h8765_4321);
    poke(4'd3, 32'hAAAA_AAAA);

    // Reset values
    check("rst ready", 32'(req_ready), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_data", resp_data, 32'd0);
    check("rst resp_err", 32'(resp_err), 32'd0);
    check("rst mem_en", 32'(mem_en), 32'd0);
    check("rst mem_func", 32'(mem_func), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wr_data", mem_wr_data, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("post rst ready", 32'(req_ready), 32'd1);

    // Loads
    run_req("ld w", FCN_LD, MT_W, 32'h8, 32'h0, 2, 32'h8765_4321, 1'b0, en_s, addr_s, wr_s);
    check("ld w en", 32'(en_s), 32'd1);
    check("ld w mem_addr", addr_s, 32'd2);
    run_req("ld b", FCN_LD, MT_B, 32'h7, 32'h0, 2, 32'hFFFF_FF80, 1'b0, en_s, addr_s, wr_s);
    run_req("ld bu", FCN_LD, MT_BU, 32'h7, 32'h0, 2, 32'h0000_0080, 1'b0, en_s, addr_s, wr_s);
    run_req("ld h", FCN_LD, MT_H, 32'h6, 32'h0, 2, 32'hFFFF_80FF, 1'b0, en_s, addr_s, wr_s);
    run_req("ld hu", FCN_LD, MT_HU, 32'h6, 32'h0, 2, 32'h0000_80FF, 1'b0, en_s, addr_s, wr_s);
    run_req("ld b0", FCN_LD, MT_B, 32'h9, 32'h0, 2, 32'h0000_0043, 1'b0, en_s, addr_s, wr_s);

    // Sub-word and word stores
    poke(4'd1, 32'h1122_3344);
    run_req("st h", FCN_ST, MT_H, 32'h6, 32'h0000_BEEF, 3, 32'h0, 1'b0, en_s, addr_s, wr_s);
    check("st h wr_data", wr_s, 32'hBEEF_3344);
    check("st h mem", mem[1], 32'hBEEF_3344);
    run_req("st b", FCN_ST, MT_B, 32'h9, 32'h0000_00A5, 3, 32'h0, 1'b0, en_s, addr_s, wr_s);
    check("st b mem", mem[2], 32'h8765_A521);
    run_req("st w", FCN_ST, MT_W, 32'h0, 32'hCAFE_F00D, 2, 32'h0, 1'b0, en_s, addr_s, wr_s);
    check("st w mem", mem[0], 32'hCAFE_F00D);

    // Misaligned requests
    run_req("mis ld w", FCN_LD, MT_W, 32'h2, 32'h0, 1, 32'h0, 1'b1, en_s, addr_s, wr_s);
    check("mis ld w en", 32'(en_s), 32'd0);
    run_req("mis st h", FCN_ST, MT_H, 32'h1, 32'h1234, 1, 32'h0, 1'b1, en_s, addr_s, wr_s);
    check("mis st h en", 32'(en_s), 32'd0);
    check("mis st h mem", mem[0], 32'hCAFE_F00D);

    // Back-to-back loads with valid held high
    pa = 0; pb = 0; rd_a = '0; rd_b = '0;
    req_valid = 1'b1; req_fcn = FCN_LD; req_typ = MT_W; req_addr = 32'h8;
    @(posedge clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 1) req_addr = 32'h4;
      if (i == 3) check("b2b ready", 32'(req_ready), 32'd1);
      if (i == 4) begin
        check("b2b busy", 32'(req_ready), 32'd0);
        req_valid = 1'b0;
      end
      if (resp_valid) begin
        if (pa == 0) begin pa = i; rd_a = resp_data; end
        else         begin pb = i; rd_b = resp_data; end
      end
    end
    check("b2b first cycle", 32'(pa), 32'd2);
    check("b2b first data", rd_a, 32'h8765_A521);
    check("b2b second cycle", 32'(pb), 32'd5);
    check("b2b second data", rd_b, 32'hBEEF_3344);

    // Reset during the WRITE of a word store
    check("rstw ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_fcn = FCN_ST; req_typ = MT_W; req_addr = 32'hC; req_wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rstw write en", 32'(mem_en), 32'd1);
    check("rstw write func", 32'(mem_func), 32'(MEM_FUNC_WR));
    #2 reset_n = 1'b0;
    #1;
    check("rstw en async", 32'(mem_en), 32'd0);
    check("rstw ready low", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rstw no resp", 32'(resp_valid), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    check("rstw ready after", 32'(req_ready), 32'd1);
    check("rstw resp after", 32'(resp_valid), 32'd0);
    check("rstw mem", mem[3], 32'hAAAA_AAAA);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
